mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between the instruction-fetch
//  port (IF) and the load/store port (D) of the CPU, for the unified-memory variant of pcpu.
//  Arbitrates, launches one memory transaction at a time and returns completions.
//  D has priority over IF; a starvation guard bounds how long IF can lose.
// PARAMETERS
//  AW          10  word/byte address width (matches 10-bit IM/DM addressing)
//  DW          32  data width
//  STARVE_MAX  4   consecutive contested D wins before IF is forced to win; range 1..15
// PORTS
//  clk       in   1   clock, all state on rising edge
//  rst       in   1   asynchronous, active-low reset
//  if_req    in   1   IF read request
//  if_addr   in   AW  IF address
//  if_gnt    out  1   IF request accepted this cycle
//  if_rvalid out  1   IF read data valid (1-cycle pulse)
//  if_rdata  out  DW  IF read data
//  d_req     in   1   D request
//  d_we      in   1   D write (1) / read (0)
//  d_be      in   4   D byte enables, writes only
//  d_addr    in   AW  D address
//  d_wdata   in   DW  D write data
//  d_gnt     out  1   D request accepted this cycle
//  d_rvalid  out  1   D completion pulse (reads and writes)
//  d_rdata   out  DW  D read data
//  m_req     out  1   memory transaction active
//  m_we      out  1   memory write
//  m_be      out  4   memory byte enables
//  m_addr    out  AW  memory address
//  m_wdata   out  DW  memory write data
//  m_ready   in   1   memory completes the transaction this cycle
//  m_rdata   in   DW  memory read data, valid when m_ready=1
// BEHAVIOUR
//  - States: IDLE, BUSY_IF, BUSY_D. Reset (rst=0, async): state=IDLE, starve_cnt=0, all outputs 0.
//  - Arbitration point: IDLE, or BUSY_* in the cycle m_ready=1. There, winner = D if d_req
//    and not (if_req and starve_cnt==STARVE_MAX); else IF if if_req; else none.
//  - Winner's gnt is asserted combinationally in that cycle; the requester may drop req next cycle.
//    Next edge: m_* fields registered from the winner, m_req=1, state=BUSY_IF/BUSY_D.
//    No winner at m_ready: m_req=0 next cycle, state=IDLE.
//  - IF transactions: m_we=0, m_be=4'b0000. D reads: m_we=0, m_be=0. D writes: m_we=1, m_be=d_be.
//  - m_* outputs are held stable while m_req=1 and m_ready=0 (any wait-state count).
//  - Completion: m_ready=1 in BUSY_X -> X_rvalid=1 the next cycle; X_rdata=m_rdata registered
//    on reads. D writes pulse d_rvalid, d_rdata unchanged. rvalid is never asserted in any other cycle.
//  - Latency: gnt at cycle 0, m_req at cycle 1, rvalid at cycle k+1 when m_ready first seen at cycle k.
//    Zero-wait memory gives one transaction per cycle back-to-back.
//  - Starvation: starve_cnt++ (saturating at STARVE_MAX) when D wins while if_req=1.
//    It clears when IF is granted. Uncontested D grants leave it unchanged.
//  - m_ready while m_req=0 is ignored. At most one transaction outstanding; never two gnts in one cycle.
//  - Reset mid-transaction: transaction abandoned, m_req drops immediately, no rvalid issued.
// STRUCTURE
//  - State encodings ARB_IDLE=2'd0, ARB_BUSY_IF=2'd1, ARB_BUSY_D=2'd2 go as `defines in ctrl_encode_def.v.
//    So do the STARVE_MAX default and the byte-enable constant BE_NONE=4'b0000.
//  - One sub-module: arb_prio_sel. It is combinational winner select plus the starve_cnt register,
//    with outputs sel_if and sel_d. Top level holds the FSM, the m_* registers and the rdata/rvalid registers.
// TESTING
//  1. Reset: rst=0 mid-BUSY_D with m_ready=0 -> all outputs 0 at once; after release, no d_rvalid.
//  2. Single IF read, 3 wait states: if_req, if_addr=0x010 -> if_gnt at c0, m_req c1..c4, m_ready c4,
//     if_rvalid c5 with if_rdata=0x2402000A.
//  3. Contention: if_req and d_req together at c0, d_we=0 -> d_gnt at c0, if_gnt at the D completion cycle.
//  4. Starvation, STARVE_MAX=4, if_req and d_req both held high, zero-wait memory:
//     grant order D,D,D,D,IF,D... -> if_gnt at the 5th arbitration.
//  5. D write: d_we=1, d_be=4'b0011, d_addr=0x3FC, d_wdata=0xDEADBEEF
//     -> m_we=1, m_be=4'b0011, m_addr=0x3FC held until m_ready; d_rvalid pulses once; d_rdata unchanged.
//  6. Back-to-back zero-wait reads: alternating IF/D on consecutive cycles -> one rvalid every cycle.
//     A spurious m_ready while IDLE produces no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2
  } arb_state_e;

  localparam int          STARVE_MAX_DEF = 4;
  localparam int          STARVE_CW      = 4;
  localparam logic [3:0]  BE_NONE        = 4'b0000;

  // Byte enables only mean something on writes; reads always present BE_NONE.
  function automatic logic [3:0] txn_be(input logic we, input logic [3:0] be);
    return we ? be : BE_NONE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// Winner select (D over IF) with a saturating starvation counter that forces an IF win.
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arb_en,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_sel_if,
  output logic o_sel_d
);

  localparam logic [STARVE_CW-1:0] STARVE_TOP = STARVE_CW'(STARVE_MAX);

  logic [STARVE_CW-1:0] r_starve_cnt;
  logic                 w_force_if;

  assign w_force_if = i_if_req && (r_starve_cnt == STARVE_TOP);
  assign o_sel_d    = i_arb_en && i_d_req && !w_force_if;
  assign o_sel_if   = i_arb_en && i_if_req && !o_sel_d;

  // Only contested D wins count; an uncontested D grant leaves the count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (o_sel_if) begin
      r_starve_cnt <= '0;
    end else if (o_sel_d && i_if_req && (r_starve_cnt != STARVE_TOP)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported variable-latency memory between the IF and D ports,
// one transaction outstanding at a time, D preferred with a starvation guard for IF.
//
//  state        | meaning
//  ARB_IDLE     | no transaction, arbitrate every cycle
//  ARB_BUSY_IF  | IF read on the memory, re-arbitrate when m_ready
//  ARB_BUSY_D   | D read/write on the memory, re-arbitrate when m_ready
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdata
);

  arb_state_e    r_state;
  logic          r_m_req;
  logic          r_m_we;
  logic [3:0]    r_m_be;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic          r_if_rvalid;
  logic [DW-1:0] r_if_rdata;
  logic          r_d_rvalid;
  logic [DW-1:0] r_d_rdata;

  logic w_busy;
  logic w_arb_en;
  logic w_sel_if;
  logic w_sel_d;
  logic w_done_if;
  logic w_done_d;

  assign w_busy    = (r_state == ARB_BUSY_IF) || (r_state == ARB_BUSY_D);
  assign w_done_if = (r_state == ARB_BUSY_IF) && m_ready;
  assign w_done_d  = (r_state == ARB_BUSY_D) && m_ready;
  // Grants are combinational, so they are also held off while reset is asserted.
  assign w_arb_en  = rst && (!w_busy || m_ready);

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .clk      (clk),
    .rst      (rst),
    .i_arb_en (w_arb_en),
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .o_sel_if (w_sel_if),
    .o_sel_d  (w_sel_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ARB_IDLE;
      r_m_req     <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_be      <= BE_NONE;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= w_done_if;
      r_d_rvalid  <= w_done_d;
      if (w_done_if) begin
        r_if_rdata <= m_rdata;
      end
      if (w_done_d && !r_m_we) begin
        r_d_rdata <= m_rdata;
      end

      case (r_state)
        ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_D: begin
          if (w_arb_en) begin
            if (w_sel_d) begin
              r_state   <= ARB_BUSY_D;
              r_m_req   <= 1'b1;
              r_m_we    <= d_we;
              r_m_be    <= txn_be(d_we, d_be);
              r_m_addr  <= d_addr;
              r_m_wdata <= d_we ? d_wdata : '0;
            end else if (w_sel_if) begin
              r_state   <= ARB_BUSY_IF;
              r_m_req   <= 1'b1;
              r_m_we    <= 1'b0;
              r_m_be    <= BE_NONE;
              r_m_addr  <= if_addr;
              r_m_wdata <= '0;
            end else begin
              r_state   <= ARB_IDLE;
              r_m_req   <= 1'b0;
              r_m_we    <= 1'b0;
              r_m_be    <= BE_NONE;
              r_m_addr  <= '0;
              r_m_wdata <= '0;
            end
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_m_req <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = w_sel_if;
  assign d_gnt     = w_sel_d;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign m_req     = r_m_req;
  assign m_we      = r_m_we;
  assign m_be      = r_m_be;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_mem_port_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic [DW-1:0] m_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_be      (m_be),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding transfer, D preferred, starvation count.
  typedef struct packed {
    logic          is_d;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  bit            md_busy;
  txn_t          md_cur;
  int            md_starve;
  bit            e_if_rv;
  bit            e_d_rv;
  logic [DW-1:0] e_if_rd;
  logic [DW-1:0] e_d_rd;
  bit            md_arb;
  bit            eg_d;
  bit            eg_if;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_all_zero", 32'(|{if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata,
                                m_req, m_we, m_be, m_addr, m_wdata}), 32'd0);
      md_busy   = 1'b0;
      md_cur    = '0;
      md_starve = 0;
      e_if_rv   = 1'b0;
      e_d_rv    = 1'b0;
      e_if_rd   = '0;
      e_d_rd    = '0;
    end else begin
      md_arb = !md_busy || m_ready;
      eg_d   = md_arb && d_req && !(if_req && md_starve == SMAX);
      eg_if  = md_arb && if_req && !eg_d;
      chk("mdl_d_gnt", d_gnt, eg_d);
      chk("mdl_if_gnt", if_gnt, eg_if);
      chk("mdl_if_rvalid", if_rvalid, e_if_rv);
      chk("mdl_d_rvalid", d_rvalid, e_d_rv);
      chk("mdl_if_rdata", if_rdata, e_if_rd);
      chk("mdl_d_rdata", d_rdata, e_d_rd);
      chk("mdl_m_req", m_req, md_busy);
      if (md_busy) begin
        chk("mdl_m_we", m_we, md_cur.we);
        chk("mdl_m_be", m_be, md_cur.be);
        chk("mdl_m_addr", m_addr, md_cur.addr);
        if (md_cur.we) chk("mdl_m_wdata", m_wdata, md_cur.wdata);
      end

      e_if_rv = md_busy && m_ready && !md_cur.is_d;
      e_d_rv  = md_busy && m_ready && md_cur.is_d;
      if (e_if_rv) e_if_rd = m_rdata;
      if (e_d_rv && !md_cur.we) e_d_rd = m_rdata;

      if (md_arb) begin
        if (eg_d) begin
          md_cur.is_d  = 1'b1;
          md_cur.we    = d_we;
          md_cur.be    = d_we ? d_be : 4'b0000;
          md_cur.addr  = d_addr;
          md_cur.wdata = d_wdata;
          if (if_req && md_starve < SMAX) md_starve++;
        end else if (eg_if) begin
          md_cur.is_d  = 1'b0;
          md_cur.we    = 1'b0;
          md_cur.be    = 4'b0000;
          md_cur.addr  = if_addr;
          md_cur.wdata = '0;
          md_starve    = 0;
        end
        md_busy = eg_d || eg_if;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit exp_d_win [6];

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'b0000; d_addr = '0; d_wdata = '0;
    m_ready = 1'b0; m_rdata = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Reset mid-BUSY_D, m_ready low
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h055;
    #1 chk("t1_d_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0;
    #1 chk("t1_m_req_busy", m_req, 1);
    chk("t1_m_addr", m_addr, 10'h055);
    d_req = 1'b1;
    rst   = 1'b0;
    #1 chk("t1_rst_m_req", m_req, 0);
    chk("t1_rst_d_gnt", d_gnt, 0);
    tick();
    m_ready = 1'b1;
    tick();
    rst = 1'b1; d_req = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t1_no_rvalid_%0d", i), d_rvalid, 0);
      chk($sformatf("t1_idle_%0d", i), m_req, 0);
      tick();
    end

    // Single IF read with 3 wait states
    if_req = 1'b1; if_addr = 10'h010;
    #1 chk("t2_if_gnt_c0", if_gnt, 1);
    chk("t2_d_gnt_c0", d_gnt, 0);
    tick();
    if_req = 1'b0;
    #1 chk("t2_m_req_c1", m_req, 1);
    chk("t2_m_addr_c1", m_addr, 10'h010);
    chk("t2_m_we_c1", m_we, 0);
    chk("t2_m_be_c1", m_be, 4'b0000);
    for (int i = 2; i < 4; i++) begin
      tick();
      #1 chk($sformatf("t2_m_req_c%0d", i), m_req, 1);
      chk($sformatf("t2_if_rvalid_c%0d", i), if_rvalid, 0);
    end
    tick();
    m_ready = 1'b1; m_rdata = 32'h2402000A;
    #1 chk("t2_m_req_c4", m_req, 1);
    tick();
    m_ready = 1'b0; m_rdata = '0;
    #1 chk("t2_if_rvalid_c5", if_rvalid, 1);
    chk("t2_if_rdata_c5", if_rdata, 32'h2402000A);
    chk("t2_m_req_c5", m_req, 0);
    tick();
    #1 chk("t2_if_rvalid_c6", if_rvalid, 0);

    // Contention: D first, IF at D completion
    if_req = 1'b1; if_addr = 10'h020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h100;
    #1 chk("t3_d_gnt_c0", d_gnt, 1);
    chk("t3_if_gnt_c0", if_gnt, 0);
    tick();
    d_req = 1'b0;
    #1 chk("t3_if_gnt_c1", if_gnt, 0);
    chk("t3_m_addr_c1", m_addr, 10'h100);
    tick();
    m_ready = 1'b1; m_rdata = 32'h11112222;
    #1 chk("t3_if_gnt_c2", if_gnt, 1);
    tick();
    if_req = 1'b0; m_rdata = 32'h33334444;
    #1 chk("t3_d_rvalid_c3", d_rvalid, 1);
    chk("t3_d_rdata_c3", d_rdata, 32'h11112222);
    chk("t3_m_addr_c3", m_addr, 10'h020);
    tick();
    m_ready = 1'b0;
    #1 chk("t3_if_rvalid_c4", if_rvalid, 1);
    chk("t3_if_rdata_c4", if_rdata, 32'h33334444);
    chk("t3_d_rvalid_c4", d_rvalid, 0);
    tick();

    // Starvation guard: D,D,D,D,IF,D
    exp_d_win = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    if_req = 1'b1; if_addr = 10'h040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h200;
    m_ready = 1'b1; m_rdata = 32'hA5A50000;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("t4_d_gnt_arb%0d", i + 1), d_gnt, exp_d_win[i]);
      chk($sformatf("t4_if_gnt_arb%0d", i + 1), if_gnt, !exp_d_win[i]);
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    m_ready = 1'b0;
    tick();

    // D write held through wait states, d_rdata untouched
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 10'h3FC; d_wdata = 32'hDEADBEEF;
    m_rdata = 32'h12345678;
    #1 chk("t5_d_gnt_c0", d_gnt, 1);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_be = 4'b0000; d_wdata = '0;
    for (int i = 1; i < 4; i++) begin
      #1 chk($sformatf("t5_m_we_c%0d", i), m_we, 1);
      chk($sformatf("t5_m_be_c%0d", i), m_be, 4'b0011);
      chk($sformatf("t5_m_addr_c%0d", i), m_addr, 10'h3FC);
      chk($sformatf("t5_m_wdata_c%0d", i), m_wdata, 32'hDEADBEEF);
      chk($sformatf("t5_d_rvalid_c%0d", i), d_rvalid, 0);
      tick();
    end
    m_ready = 1'b1;
    #1 chk("t5_m_req_c4", m_req, 1);
    tick();
    m_ready = 1'b0;
    #1 chk("t5_d_rvalid_c5", d_rvalid, 1);
    chk("t5_d_rdata_kept", d_rdata, 32'hA5A50000);
    tick();
    #1 chk("t5_d_rvalid_c6", d_rvalid, 0);

    // Back-to-back zero-wait alternating reads, then spurious m_ready while idle
    if_req = 1'b1; if_addr = 10'h001;
    #1 chk("t6_if_gnt_c0", if_gnt, 1);
    tick();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h002;
    m_ready = 1'b1; m_rdata = 32'h0000_0100;
    #1 chk("t6_d_gnt_c1", d_gnt, 1);
    tick();
    d_req = 1'b0; if_req = 1'b1; if_addr = 10'h003; m_rdata = 32'h0000_0200;
    #1 chk("t6_if_rvalid_c2", if_rvalid, 1);
    chk("t6_if_rdata_c2", if_rdata, 32'h0000_0100);
    chk("t6_d_rvalid_c2", d_rvalid, 0);
    chk("t6_if_gnt_c2", if_gnt, 1);
    tick();
    if_req = 1'b0; d_req = 1'b1; d_addr = 10'h004; m_rdata = 32'h0000_0300;
    #1 chk("t6_d_rvalid_c3", d_rvalid, 1);
    chk("t6_d_rdata_c3", d_rdata, 32'h0000_0200);
    chk("t6_d_gnt_c3", d_gnt, 1);
    tick();
    d_req = 1'b0; m_rdata = 32'h0000_0400;
    #1 chk("t6_if_rvalid_c4", if_rvalid, 1);
    chk("t6_if_rdata_c4", if_rdata, 32'h0000_0300);
    tick();
    m_rdata = 32'hBAD0BAD0;
    #1 chk("t6_d_rvalid_c5", d_rvalid, 1);
    chk("t6_d_rdata_c5", d_rdata, 32'h0000_0400);
    chk("t6_m_req_c5", m_req, 0);
    tick();
    #1 chk("t6_spur_if_rvalid", if_rvalid, 0);
    chk("t6_spur_d_rvalid", d_rvalid, 0);
    tick();
    m_ready = 1'b0;
    #1 chk("t6_spur_if_rvalid2", if_rvalid, 0);
    chk("t6_if_rdata_kept", if_rdata, 32'h0000_0300);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1);
  end

endmodule
